// File: rtl/rj_rx_deser.sv
// Right-justified serial audio receiver: deserializes Sdata, splits samples by Lrclk and
// drives write strobe, row and clear for the per-channel sample memories. Optional macro: RJ_BITCNT_CHK_EN.
module rj_rx_deser #(
    parameter int DATA_W    = 16,
    parameter int ROW_W     = 4,
    parameter bit RIGHT_LVL = 1'b1
) (
    input  logic              Sclk,
    input  logic              clear_n,
    input  logic              enable,
    input  logic              Lrclk,
    input  logic              Sdata,
    output logic [DATA_W-1:0] dataL,
    output logic [DATA_W-1:0] dataR,
    output logic              rj_statusL,
    output logic              rj_statusR,
    output logic [ROW_W-1:0]  row,
    output logic              mem_clear,
    output logic              frame_wrap,
    output logic              err_short
);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic              lr_q;
    logic              lr_edge;
    logic              old_is_right;
    logic              vld_l_p0;
    logic              vld_r_p0;
    logic              mclr_l;
    logic              mclr_r;
    logic              busy;
    logic              drop_short;

    assign lr_edge      = (Lrclk != lr_q);
    assign old_is_right = (lr_q == RIGHT_LVL);
    // A capture still travelling toward its strobe blocks a newer one (sub-3-cycle halves).
    assign busy         = vld_l_p0 | vld_r_p0 | rj_statusL | rj_statusR;

`ifdef RJ_BITCNT_CHK_EN
    localparam logic [5:0] MIN_BITS = 6'(DATA_W);

    logic [5:0] bitcnt;

    function automatic logic [5:0] sat_inc(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

    always_ff @(posedge Sclk or negedge clear_n) begin
        if (!clear_n) begin
            bitcnt <= '0;
        end else if (lr_edge) begin
            bitcnt <= 6'd1;
        end else begin
            bitcnt <= sat_inc(bitcnt);
        end
    end

    assign drop_short = (bitcnt < MIN_BITS);
`else
    assign drop_short = 1'b0;
`endif

    always_ff @(posedge Sclk or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            shreg      <= '0;
            lr_q       <= 1'b0;
            dataL      <= '0;
            dataR      <= '0;
            vld_l_p0   <= 1'b0;
            vld_r_p0   <= 1'b0;
            rj_statusL <= 1'b0;
            rj_statusR <= 1'b0;
            row        <= '0;
            mem_clear  <= 1'b0;
            frame_wrap <= 1'b0;
            err_short  <= 1'b0;
            mclr_l     <= 1'b0;
            mclr_r     <= 1'b0;
        end else begin
            shreg      <= {shreg[DATA_W-2:0], Sdata};
            lr_q       <= Lrclk;
            vld_l_p0   <= 1'b0;
            vld_r_p0   <= 1'b0;
            rj_statusL <= 1'b0;
            rj_statusR <= 1'b0;
            mem_clear  <= 1'b0;
            frame_wrap <= 1'b0;

            if (!enable) begin
                state <= IDLE;
            end else begin
                // stage p0: capture the word that ended at this Lrclk edge
                case (state)
                    IDLE: begin
                        state     <= SYNC;
                        row       <= '0;
                        err_short <= 1'b0;
                        mclr_l    <= 1'b1;
                        mclr_r    <= 1'b1;
                    end
                    SYNC: begin
                        if (lr_edge) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (lr_edge && !busy) begin
                            if (drop_short) begin
                                err_short <= 1'b1;
                            end else if (old_is_right) begin
                                dataR    <= shreg;
                                vld_r_p0 <= 1'b1;
                            end else begin
                                dataL    <= shreg;
                                vld_l_p0 <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase

                // stage p1: write strobe, data already settled for one cycle
                rj_statusL <= vld_l_p0;
                rj_statusR <= vld_r_p0;
                if (vld_l_p0) begin
                    mem_clear <= mclr_l;
                    mclr_l    <= 1'b0;
                end
                if (vld_r_p0) begin
                    mem_clear <= mclr_r;
                    mclr_r    <= 1'b0;
                end

                // stage p2: advance row once the right strobe has dropped
                if (rj_statusR) begin
                    row        <= row + 1'b1;
                    frame_wrap <= &row;
                end
            end
        end
    end

endmodule
